cpu_host_ctrl: RTL and testbench

- Host-side initiator for the processor core's req/done run protocol.
- Preloads the core's data memory and holds the core in reset for a fixed window.
- Issues the one-cycle req pulse, then waits for done under a watchdog.
- After a completed run, streams a result window of data memory out through a valid/ready port. Sits beside the core in the bench/SoC shell and owns the data-memory port whenever the core is not running.

---
 rtl/cpu_host_ctrl.sv | 141 ++++++++++++++
 tb/tb_cpu_host_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_ctrl.sv
// Host-side launcher for the core's req/done run protocol: preloads data memory,
// pulses the core out of reset, watches the run, then streams a result window.
module cpu_host_ctrl #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 16,
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned MAX_CYC = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam int unsigned LW  = AW + 1;
  localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_KICK, S_RUN, S_DRAIN, S_FIN, S_TMO
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   base_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   idx_q;
  logic [RCW-1:0]  rcnt_q;
  logic [CW-1:0]   cyc_q;

  // Control FSM plus the latched run parameters and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rcnt_q  <= '0;
      cyc_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN, S_TMO: begin
          if (start) begin
            base_q  <= rd_base;
            len_q   <= rd_len;
            idx_q   <= '0;
            rcnt_q  <= '0;
            cyc_q   <= '0;
            state_q <= S_CRST;
          end
        end
        S_CRST: begin
          if (rcnt_q == RCW'(RST_CYC - 1)) state_q <= S_KICK;
          else                             rcnt_q  <= rcnt_q + RCW'(1);
        end
        S_KICK: state_q <= S_RUN;
        S_RUN: begin
          // Completion takes priority over watchdog expiry in the same cycle.
          if (core_done) begin
            state_q <= (len_q == '0) ? S_FIN : S_DRAIN;
          end else begin
            cyc_q <= cyc_q + CW'(1);
            if (cyc_q == CW'(MAX_CYC - 1)) state_q <= S_TMO;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx_q == len_q - LW'(1)) state_q <= S_FIN;
            else                         idx_q   <= idx_q + LW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Port decode from the registered state; the memory and stream paths are
  // combinational so a read returns in the same cycle it is addressed.
  always_comb begin
    mem_own    = 1'b1;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_reset = 1'b1;
    core_req   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = 1'b0;
    finished   = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_wr_en = ld_valid;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
      end
      S_CRST: busy = 1'b1;
      S_KICK: begin
        busy       = 1'b1;
        mem_own    = 1'b0;
        core_reset = 1'b0;
        core_req   = 1'b1;
      end
      S_RUN: begin
        busy       = 1'b1;
        mem_own    = 1'b0;
        core_reset = 1'b0;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        mem_addr  = base_q + idx_q[AW-1:0];
        out_valid = 1'b1;
        out_data  = mem_rdata;
      end
      S_FIN:   finished = 1'b1;
      S_TMO:   timeout  = 1'b1;
      default: ;
    endcase
  end

  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Directed bench for cpu_host_ctrl with a behavioural core (delayed done) and
// a combinational-read data memory.
module tb_cpu_host_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, ld_valid;
  logic [7:0]  ld_addr, ld_data, rd_base;
  logic [8:0]  rd_len;
  logic        mem_own, mem_wr_en;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        core_reset, core_req, core_done;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        busy, finished, timeout;
  logic [15:0] cycle_count;

  int errors = 0;
  int checks = 0;

  cpu_host_ctrl #(.AW(8), .DW(8), .CW(16), .RST_CYC(4), .MAX_CYC(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .rd_base(rd_base), .rd_len(rd_len),
    .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_reset(core_reset),
    .core_req(core_req), .core_done(core_done), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .finished(finished), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (mem_own && mem_wr_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Core model: done rises after done_lat RUN cycles with done low (-1 = never).
  int done_lat = -1;
  int ctr = 0;
  bit armed = 0;
  bit saw_valid = 0;
  always @(negedge clk) begin
    if (out_valid) saw_valid = 1'b1;
    if (core_reset) begin
      armed = 0; ctr = 0; core_done = 1'b0;
    end else if (core_req) begin
      armed = 1; ctr = 0; core_done = 1'b0;
    end else if (armed) begin
      ctr++;
      core_done = (done_lat >= 0) && (ctr > done_lat);
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] d;
    logic       exp_we;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
  } pl_t;

  logic [7:0] exp_q[$];
  bit         rdy_pat[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start; report core_reset window length and req pulse length.
  task automatic launch(input logic [7:0] base, input logic [8:0] len,
                        output int crst, output int kick);
    rd_base = base; rd_len = len; start = 1'b1; saw_valid = 0;
    tick();
    start = 1'b0;
    crst = 0; kick = 0;
    while (core_reset && crst < 20) begin crst++; tick(); end
    while (core_req && kick < 5) begin kick++; tick(); end
  endtask

  task automatic wait_end(input string tag, output int runs);
    int n = 0;
    runs = 0;
    while (!(out_valid || finished || timeout) && n < 300) begin
      if (busy && !core_reset && !core_req) runs++;
      tick(); n++;
    end
    chk({tag, "_wait_bound"}, 32'(n < 300), 32'd1);
  endtask

  task automatic drain(input string tag);
    int hs = 0;
    int n = 0;
    while (!finished && !timeout && n < 100) begin
      out_ready = (n < rdy_pat.size()) ? rdy_pat[n] : 1'b1;
      #1;
      if (out_valid) begin
        if (hs < exp_q.size()) chk({tag, "_data"}, 32'(out_data), 32'(exp_q[hs]));
        else                   chk({tag, "_extra_word"}, 32'd1, 32'd0);
        if (out_ready) hs++;
      end
      tick(); n++;
    end
    out_ready = 1'b0;
    chk({tag, "_handshakes"}, 32'(hs), 32'(exp_q.size()));
    chk({tag, "_finished"}, 32'(finished), 32'd1);
  endtask

  initial begin
    pl_t tbl[9];
    int crst, kick, runs;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    rd_base = '0; rd_len = '0; out_ready = 1'b0; core_done = 1'b0;

    tbl[0] = '{1'b1, 8'h40, 8'h11, 1'b1, 8'h40, 8'h11};
    tbl[1] = '{1'b1, 8'h41, 8'h22, 1'b1, 8'h41, 8'h22};
    tbl[2] = '{1'b0, 8'h42, 8'h99, 1'b0, 8'h42, 8'h99};
    tbl[3] = '{1'b1, 8'hFE, 8'hA1, 1'b1, 8'hFE, 8'hA1};
    tbl[4] = '{1'b1, 8'hFF, 8'hA2, 1'b1, 8'hFF, 8'hA2};
    tbl[5] = '{1'b1, 8'h00, 8'hA3, 1'b1, 8'h00, 8'hA3};
    tbl[6] = '{1'b1, 8'h50, 8'h31, 1'b1, 8'h50, 8'h31};
    tbl[7] = '{1'b1, 8'h51, 8'h32, 1'b1, 8'h51, 8'h32};
    tbl[8] = '{1'b1, 8'h52, 8'h33, 1'b1, 8'h52, 8'h33};

    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_mem_own", 32'(mem_own), 32'd1);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_req", 32'(core_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", {29'd0, busy, finished, timeout}, 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);

    // Preload vectors through the IDLE write mux.
    for (int i = 0; i < 9; i++) begin
      ld_valid = tbl[i].v; ld_addr = tbl[i].a; ld_data = tbl[i].d;
      #1;
      chk($sformatf("pl%0d_we", i), 32'(mem_wr_en), 32'(tbl[i].exp_we));
      chk($sformatf("pl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("pl%0d_wdata", i), 32'(mem_wdata), 32'(tbl[i].exp_data));
      tick();
    end
    ld_valid = 1'b0;
    chk("pl_skip_unwritten", 32'(mem[8'h42]), 32'h00);

    // Basic run: done 10 cycles after req, two-word stream.
    done_lat = 10;
    launch(8'h40, 9'd2, crst, kick);
    chk("t1_crst_len", 32'(crst), 32'd4);
    chk("t1_req_len", 32'(kick), 32'd1);
    chk("t1_run_mem_own", 32'(mem_own), 32'd0);
    wait_end("t1", runs);
    chk("t1_cycle_count", 32'(cycle_count), 32'd10);
    chk("t1_drain_core_reset", 32'(core_reset), 32'd1);
    exp_q = '{8'h11, 8'h22};
    rdy_pat = '{};
    drain("t1");
    chk("t1_fin_count_held", 32'(cycle_count), 32'd10);
    chk("t1_fin_busy", 32'(busy), 32'd0);

    // Backpressure during drain, relaunched from FIN without new preload.
    done_lat = 3;
    launch(8'h50, 9'd3, crst, kick);
    wait_end("t2", runs);
    chk("t2_cycle_count", 32'(cycle_count), 32'd3);
    exp_q = '{8'h31, 8'h32, 8'h33};
    rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    drain("t2");

    // Watchdog: done never rises.
    done_lat = -1;
    launch(8'h40, 9'd2, crst, kick);
    wait_end("t3", runs);
    chk("t3_timeout", 32'(timeout), 32'd1);
    chk("t3_finished", 32'(finished), 32'd0);
    chk("t3_run_cycles", 32'(runs), 32'd16);
    chk("t3_cycle_count", 32'(cycle_count), 32'd16);
    tick(); tick();
    chk("t3_no_valid", 32'(saw_valid), 32'd0);
    chk("t3_tmo_core_reset", 32'(core_reset), 32'd1);

    // Done on the same cycle the watchdog would expire.
    done_lat = 15;
    launch(8'h40, 9'd2, crst, kick);
    wait_end("t4", runs);
    chk("t4_timeout", 32'(timeout), 32'd0);
    chk("t4_in_drain", 32'(out_valid), 32'd1);
    chk("t4_cycle_count", 32'(cycle_count), 32'd15);
    exp_q = '{8'h11, 8'h22};
    rdy_pat = '{};
    drain("t4");

    // Address wrap across the top of memory.
    done_lat = 2;
    launch(8'hFE, 9'd3, crst, kick);
    wait_end("t5", runs);
    exp_q = '{8'hA1, 8'hA2, 8'hA3};
    drain("t5");

    // Zero-length window goes straight to FIN.
    done_lat = 4;
    launch(8'h40, 9'd0, crst, kick);
    wait_end("t6", runs);
    chk("t6_finished", 32'(finished), 32'd1);
    chk("t6_cycle_count", 32'(cycle_count), 32'd4);
    tick();
    chk("t6_no_valid", 32'(saw_valid), 32'd0);

    // Ignored start/ld during RUN, then reset mid-drain.
    done_lat = 8;
    launch(8'h50, 9'd3, crst, kick);
    start = 1'b1; rd_base = 8'h40; rd_len = 9'd2;
    ld_valid = 1'b1; ld_addr = 8'h60; ld_data = 8'h77;
    #1;
    chk("t7_run_no_wr", 32'(mem_wr_en), 32'd0);
    tick();
    start = 1'b0; ld_valid = 1'b0;
    chk("t7_still_run", {30'd0, busy, core_reset}, 32'b10);
    chk("t7_mem_untouched", 32'(mem[8'h60]), 32'h00);
    wait_end("t7", runs);
    chk("t7_out_valid", 32'(out_valid), 32'd1);
    chk("t7_base_kept", 32'(out_data), 32'h31);
    reset = 1'b1;
    tick();
    chk("t7_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_core_reset", 32'(core_reset), 32'd1);
    chk("t7_rst_count", 32'(cycle_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("t7_idle_mem_own", 32'(mem_own), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
